// File: rtl/hdp_spi_engine_if.sv
// Request/response and HDP serial-pin bundle for hdp_spi_engine.
// The slave modport is the engine; the master modport is the sequencer plus HDP device side.
interface hdp_spi_engine_if;
  logic       i_txBegin;
  logic [6:0] i_txAddress;
  logic [7:0] i_txData;
  logic       o_txBusy;
  logic       o_txDone;
  logic       o_txError;
  logic       i_rxBegin;
  logic [6:0] i_rxAddress;
  logic [7:0] o_rxData;
  logic       o_rxBusy;
  logic       o_rxDone;
  logic       i_sout;
  logic       o_sen;
  logic       o_sck;
  logic       o_sdat;

  modport slave (
    input  i_txBegin, i_txAddress, i_txData, i_rxBegin, i_rxAddress, i_sout,
    output o_txBusy, o_txDone, o_txError, o_rxData, o_rxBusy, o_rxDone,
           o_sen, o_sck, o_sdat
  );

  modport master (
    output i_txBegin, i_txAddress, i_txData, i_rxBegin, i_rxAddress, i_sout,
    input  o_txBusy, o_txDone, o_txError, o_rxData, o_rxBusy, o_rxDone,
           o_sen, o_sck, o_sdat
  );
endinterface

// File: rtl/hdp_spi_engine.sv
// Bit-level SPI master serialising single-register HDP reads/writes as 16-bit frames.
// Define HDP_SPI_WRITE_VERIFY_EN to follow every write with an automatic readback check.
module hdp_spi_engine #(
  parameter int unsigned CLOCKS_PER_BIT = 50
) (
  input  logic               i_clock,
  input  logic               i_reset,
  hdp_spi_engine_if.slave    io_hdp
);

  localparam int unsigned H  = CLOCKS_PER_BIT / 2;
  localparam int unsigned CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP,
    S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_sub, w_sub_nxt;
  logic [3:0]      r_bit, w_bit_nxt;
  logic [15:0]     r_frame, w_frame_nxt;
  logic            r_read, w_read_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_sen, w_sen_nxt;
  logic            r_sck, w_sck_nxt;
  logic            r_sdat, w_sdat_nxt;
  logic            r_tx_busy, w_tx_busy_nxt;
  logic            r_tx_done, w_tx_done_nxt;
  logic            r_rx_busy, w_rx_busy_nxt;
  logic            r_rx_done, w_rx_done_nxt;
  logic [7:0]      r_rx_data, w_rx_data_nxt;
`ifdef HDP_SPI_WRITE_VERIFY_EN
  logic            r_verify, w_verify_nxt;
  logic [6:0]      r_addr, w_addr_nxt;
  logic [7:0]      r_wdata, w_wdata_nxt;
  logic            r_tx_error, w_tx_error_nxt;
`endif

  // Next-state, datapath and registered-output values
  always_comb begin
    w_state_nxt    = r_state;
    w_sub_nxt      = r_sub;
    w_bit_nxt      = r_bit;
    w_frame_nxt    = r_frame;
    w_read_nxt     = r_read;
    w_shift_nxt    = r_shift;
    w_tx_busy_nxt  = r_tx_busy;
    w_tx_done_nxt  = 1'b0;
    w_rx_busy_nxt  = r_rx_busy;
    w_rx_done_nxt  = 1'b0;
    w_rx_data_nxt  = r_rx_data;
`ifdef HDP_SPI_WRITE_VERIFY_EN
    w_verify_nxt   = r_verify;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_tx_error_nxt = r_tx_error;
`endif

    unique case (r_state)
      S_IDLE: begin
        w_sub_nxt = '0;
        w_bit_nxt = '0;
        if (io_hdp.i_txBegin) begin
          w_state_nxt   = S_LEAD;
          w_frame_nxt   = {1'b0, io_hdp.i_txAddress, io_hdp.i_txData};
          w_read_nxt    = 1'b0;
          w_tx_busy_nxt = 1'b1;
`ifdef HDP_SPI_WRITE_VERIFY_EN
          w_verify_nxt  = 1'b0;
          w_addr_nxt    = io_hdp.i_txAddress;
          w_wdata_nxt   = io_hdp.i_txData;
`endif
        end else if (io_hdp.i_rxBegin) begin
          w_state_nxt   = S_LEAD;
          w_frame_nxt   = {1'b1, io_hdp.i_rxAddress, 8'h00};
          w_read_nxt    = 1'b1;
          w_rx_busy_nxt = 1'b1;
`ifdef HDP_SPI_WRITE_VERIFY_EN
          w_verify_nxt  = 1'b0;
`endif
        end
      end

      S_LEAD: begin
        if (r_sub == CW'(H - 1)) begin
          w_state_nxt = S_SHIFT;
          w_sub_nxt   = '0;
        end else begin
          w_sub_nxt   = r_sub + CW'(1);
        end
      end

      S_SHIFT: begin
        // Read data is captured on the first high cycle of SCK for bits 7:0
        if (r_read && r_bit[3] && (r_sub == CW'(H))) begin
          w_shift_nxt = {r_shift[6:0], io_hdp.i_sout};
        end
        if (r_sub == CW'(CLOCKS_PER_BIT - 1)) begin
          w_sub_nxt   = '0;
          w_frame_nxt = {r_frame[14:0], 1'b0};
          if (r_bit == 4'd15) begin
            w_state_nxt = S_TRAIL;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt   = r_bit + 4'd1;
          end
        end else begin
          w_sub_nxt = r_sub + CW'(1);
        end
      end

      S_TRAIL: begin
        if (r_sub == CW'(H - 1)) begin
          w_state_nxt = S_GAP;
          w_sub_nxt   = '0;
        end else begin
          w_sub_nxt   = r_sub + CW'(1);
        end
      end

      S_GAP: begin
        if (r_sub == CW'(CLOCKS_PER_BIT - 1)) begin
          w_state_nxt = S_DONE;
          w_sub_nxt   = '0;
        end else begin
          w_sub_nxt   = r_sub + CW'(1);
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
`ifdef HDP_SPI_WRITE_VERIFY_EN
        if (!r_read) begin
          // Chain a hidden readback of the address just written
          w_state_nxt  = S_LEAD;
          w_frame_nxt  = {1'b1, r_addr, 8'h00};
          w_read_nxt   = 1'b1;
          w_verify_nxt = 1'b1;
        end else if (r_verify) begin
          w_tx_done_nxt  = 1'b1;
          w_tx_busy_nxt  = 1'b0;
          w_tx_error_nxt = (r_shift != r_wdata);
        end else begin
          w_rx_done_nxt = 1'b1;
          w_rx_busy_nxt = 1'b0;
          w_rx_data_nxt = r_shift;
        end
`else
        if (r_read) begin
          w_rx_done_nxt = 1'b1;
          w_rx_busy_nxt = 1'b0;
          w_rx_data_nxt = r_shift;
        end else begin
          w_tx_done_nxt = 1'b1;
          w_tx_busy_nxt = 1'b0;
        end
`endif
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_sen_nxt  = !((w_state_nxt == S_LEAD) || (w_state_nxt == S_SHIFT) ||
                   (w_state_nxt == S_TRAIL));
    w_sck_nxt  = (w_state_nxt == S_SHIFT) && (w_sub_nxt >= CW'(H));
    w_sdat_nxt = ((w_state_nxt == S_LEAD) || (w_state_nxt == S_SHIFT)) ?
                 w_frame_nxt[15] : 1'b0;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_sub      <= '0;
      r_bit      <= '0;
      r_frame    <= '0;
      r_read     <= 1'b0;
      r_shift    <= '0;
      r_sen      <= 1'b1;
      r_sck      <= 1'b0;
      r_sdat     <= 1'b0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_rx_busy  <= 1'b0;
      r_rx_done  <= 1'b0;
      r_rx_data  <= '0;
`ifdef HDP_SPI_WRITE_VERIFY_EN
      r_verify   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tx_error <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_sub      <= w_sub_nxt;
      r_bit      <= w_bit_nxt;
      r_frame    <= w_frame_nxt;
      r_read     <= w_read_nxt;
      r_shift    <= w_shift_nxt;
      r_sen      <= w_sen_nxt;
      r_sck      <= w_sck_nxt;
      r_sdat     <= w_sdat_nxt;
      r_tx_busy  <= w_tx_busy_nxt;
      r_tx_done  <= w_tx_done_nxt;
      r_rx_busy  <= w_rx_busy_nxt;
      r_rx_done  <= w_rx_done_nxt;
      r_rx_data  <= w_rx_data_nxt;
`ifdef HDP_SPI_WRITE_VERIFY_EN
      r_verify   <= w_verify_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_tx_error <= w_tx_error_nxt;
`endif
    end
  end

  assign io_hdp.o_sen     = r_sen;
  assign io_hdp.o_sck     = r_sck;
  assign io_hdp.o_sdat    = r_sdat;
  assign io_hdp.o_txBusy  = r_tx_busy;
  assign io_hdp.o_txDone  = r_tx_done;
  assign io_hdp.o_rxBusy  = r_rx_busy;
  assign io_hdp.o_rxDone  = r_rx_done;
  assign io_hdp.o_rxData  = r_rx_data;
`ifdef HDP_SPI_WRITE_VERIFY_EN
  assign io_hdp.o_txError = r_tx_error;
`else
  assign io_hdp.o_txError = 1'b0;
`endif

endmodule

// File: tb/tb_hdp_spi_engine.sv
// Scoreboard bench for hdp_spi_engine with a register-file HDP device model.
// Honours HDP_SPI_WRITE_VERIFY_EN to match the build under test.
module tb_hdp_spi_engine;

  localparam int unsigned CPB    = 50;
  localparam int          LAT_RD = 18 * CPB + 1;
`ifdef HDP_SPI_WRITE_VERIFY_EN
  localparam int          LAT_WR = 36 * CPB + 2;
`else
  localparam int          LAT_WR = 18 * CPB + 1;
`endif

  typedef struct {
    bit         is_read;
    logic [7:0] rdata;
    bit         err;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t        sbq[$];
  logic [15:0] frq[$];
  logic [7:0]  ref_mem [128];
  logic [7:0]  hdp_mem [128];
  bit          hdp_bad = 0;
  logic [7:0]  hold = 8'h00;

  hdp_spi_engine_if bus ();

  hdp_spi_engine #(.CLOCKS_PER_BIT(CPB)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_hdp  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, req, cyc);
    end
  endfunction

  // Done-pulse monitor: pops the scoreboard whenever a done pulse appears
  bit seen_tx = 0, seen_rx = 0;
  always @(negedge clk) begin
    if (rst) begin
      seen_tx = 0;
      seen_rx = 0;
    end else begin
      if (bus.o_txBusy) seen_tx = 1;
      if (bus.o_rxBusy) seen_rx = 1;
      if (bus.o_txDone || bus.o_rxDone) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", {30'd0, bus.o_txDone, bus.o_rxDone}, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_kind", {30'd0, bus.o_txDone, bus.o_rxDone}, e.is_read ? 32'd1 : 32'd2);
          chk("latency", 32'(cyc), 32'(e.due));
          chk("busy_at_done", {30'd0, bus.o_txBusy, bus.o_rxBusy}, 32'd0);
          chk("busy_kind", {30'd0, seen_tx, seen_rx}, e.is_read ? 32'd1 : 32'd2);
          if (e.is_read) begin
            chk("rx_data", 32'(bus.o_rxData), 32'(e.rdata));
            hold = e.rdata;
          end else begin
            chk("tx_error", 32'(bus.o_txError), 32'(e.err));
            chk("rx_data_held", 32'(bus.o_rxData), 32'(hold));
          end
        end
        seen_tx = 0;
        seen_rx = 0;
      end
    end
  end

  // HDP device model: captures frames on SCK rise, answers reads on SCK fall
  logic        prev_sen = 1'b1, prev_sck = 1'b0;
  int          rises = 0, lowcnt = 0;
  logic [15:0] cap = '0;
  logic [7:0]  resp = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_sen = 1'b1;
      prev_sck = 1'b0;
      rises    = 0;
      lowcnt   = 0;
    end else begin
      if (prev_sen && !bus.o_sen) begin
        rises  = 0;
        lowcnt = 0;
        cap    = '0;
        bus.i_sout = 1'($urandom);
      end
      if (!bus.o_sen) lowcnt++;
      if (!prev_sck && bus.o_sck) begin
        cap = {cap[14:0], bus.o_sdat};
        rises++;
        if (rises == 8) resp = hdp_mem[cap[6:0]];
      end
      if (prev_sck && !bus.o_sck) begin
        if (15 - rises <= 7 && 15 - rises >= 0) bus.i_sout = resp[15 - rises];
        else bus.i_sout = 1'($urandom);
      end
      if (!prev_sen && bus.o_sen) begin
        chk("sck_rises", 32'(rises), 32'd16);
        chk("sen_low_cycles", 32'(lowcnt), 32'(17 * CPB));
        if (frq.size() == 0) chk("unexpected_frame", 32'(cap), 32'hFFFF_FFFF);
        else chk("frame_bits", 32'(cap), 32'(frq.pop_front()));
        if (!cap[15]) hdp_mem[cap[14:8]] = hdp_bad ? (cap[7:0] ^ 8'h01) : cap[7:0];
      end
      prev_sen = bus.o_sen;
      prev_sck = bus.o_sck;
    end
  end

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input bit bad, input bit also_rx);
    exp_t e;
    @(negedge clk);
    bus.i_txBegin   = 1'b1;
    bus.i_txAddress = a;
    bus.i_txData    = d;
    if (also_rx) begin
      bus.i_rxBegin   = 1'b1;
      bus.i_rxAddress = 7'($urandom);
    end
    hdp_bad = bad;
    frq.push_back({1'b0, a, d});
`ifdef HDP_SPI_WRITE_VERIFY_EN
    frq.push_back({1'b1, a, 8'h00});
    e.err = bad;
`else
    e.err = 1'b0;
`endif
    e.is_read = 1'b0;
    e.rdata   = 8'h00;
    e.due     = cyc + 1 + LAT_WR;
    sbq.push_back(e);
    ref_mem[a] = bad ? (d ^ 8'h01) : d;
    @(negedge clk);
    bus.i_txBegin   = 1'b0;
    bus.i_rxBegin   = 1'b0;
    bus.i_txAddress = 7'($urandom);
    bus.i_txData    = 8'($urandom);
  endtask

  task automatic do_read(input logic [6:0] a);
    exp_t e;
    @(negedge clk);
    bus.i_rxBegin   = 1'b1;
    bus.i_rxAddress = a;
    frq.push_back({1'b1, a, 8'h00});
    e.is_read = 1'b1;
    e.rdata   = ref_mem[a];
    e.err     = 1'b0;
    e.due     = cyc + 1 + LAT_RD;
    sbq.push_back(e);
    @(negedge clk);
    bus.i_rxBegin   = 1'b0;
    bus.i_rxAddress = 7'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && (sbq.size() != 0 || frq.size() != 0); i++) @(negedge clk);
    if (sbq.size() != 0 || frq.size() != 0) begin
      chk("completion_timeout", 32'(sbq.size() + frq.size()), 32'd0);
      sbq.delete();
      frq.delete();
    end
    repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask

  int         s;
  logic [7:0] old;

  initial begin
    rst             = 1'b1;
    bus.i_txBegin   = 1'b0;
    bus.i_txAddress = '0;
    bus.i_txData    = '0;
    bus.i_rxBegin   = 1'b0;
    bus.i_rxAddress = '0;
    bus.i_sout      = 1'b0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      hdp_mem[i] = ref_mem[i];
    end
    ref_mem[7'h78] = 8'h20;
    hdp_mem[7'h78] = 8'h20;

    repeat (3) @(negedge clk);
    chk("rst_sen", 32'(bus.o_sen), 32'd1);
    chk("rst_sck", 32'(bus.o_sck), 32'd0);
    chk("rst_sdat", 32'(bus.o_sdat), 32'd0);
    chk("rst_rxdata", 32'(bus.o_rxData), 32'd0);
    chk("rst_flags", {26'd0, bus.o_txBusy, bus.o_txDone, bus.o_txError,
                      bus.o_rxBusy, bus.o_rxDone, 1'b0}, 32'd0);
    rst = 1'b0;

    do_write(7'h01, 8'h02, 1'b0, 1'b0);
    wait_idle();
    do_read(7'h78);
    wait_idle();
    do_write(7'h15, 8'hA5, 1'b0, 1'b1);
    wait_idle();

    do_write(7'h22, 8'h5A, 1'b0, 1'b0);
    s = cyc;
    while (cyc < s + 299) @(negedge clk);
    bus.i_rxBegin   = 1'b1;
    bus.i_rxAddress = 7'h33;
    @(negedge clk);
    bus.i_rxBegin   = 1'b0;
    wait_idle();

    // Abort a write 400 cycles in; it must leave no trace
    old = ref_mem[7'h40];
    do_write(7'h40, ~old, 1'b0, 1'b0);
    s = cyc;
    while (cyc < s + 400) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_sen", 32'(bus.o_sen), 32'd1);
    chk("abort_sck", 32'(bus.o_sck), 32'd0);
    chk("abort_busy", {30'd0, bus.o_txBusy, bus.o_rxBusy}, 32'd0);
    sbq.delete();
    frq.delete();
    ref_mem[7'h40] = old;
    hold = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (1200) @(negedge clk);
    do_read(7'h40);
    wait_idle();

    do_write(7'h08, 8'h30, 1'b1, 1'b0);
    wait_idle();
    do_write(7'h08, 8'h30, 1'b0, 1'b0);
    wait_idle();
    do_read(7'h08);
    wait_idle();

    for (int n = 0; n < 14; n++) begin
      logic [6:0] a;
      a = 7'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) do_read(a);
      else do_write(a, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      wait_idle();
    end

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdp_spi_engine.md
Name: hdp_spi_engine

Overview:
- Bit-level SPI master for HDP configuration-register access.
- Sits directly below the comms startup/shutdown sequencer.
- Accepts single-register write or read requests (7-bit address, 8-bit data) and serialises each as one 16-bit frame on the HDP serial pins.
- Returns a one-cycle done pulse per request and, for reads, the captured byte.

Parameters:
- CLOCKS_PER_BIT, 50, i_clock cycles per SCK period; must be even and ≥2. Half period H = CLOCKS_PER_BIT/2.

Ports:
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_txBegin  in  1  write request strobe, sampled in IDLE only
- i_txAddress  in  7  write register address
- i_txData  in  8  write data
- o_txBusy  out  1  write frame in progress
- o_txDone  out  1  one-cycle pulse, write complete
- o_txError  out  1  write-verify mismatch flag (see Optional Feature)
- i_rxBegin  in  1  read request strobe, sampled in IDLE only
- i_rxAddress  in  7  read register address
- o_rxData  out  8  last byte read, held until next read completes
- o_rxBusy  out  1  read frame in progress
- o_rxDone  out  1  one-cycle pulse, read complete
- i_sout  in  1  HDP serial data out
- o_sen  out  1  chip enable, active low
- o_sck  out  1  serial clock, idles low
- o_sdat  out  1  serial data to HDP

Behaviour:
- Reset values (asynchronous): o_sen=1, o_sck=0, o_sdat=0, o_rxData=0x00; all busy/done/error flags 0; state IDLE.
- Reset mid-frame aborts immediately. No done pulse is issued and the request is not replayed.
- Frame format: 16 bits, MSB first.
  - Bit15 = R/W (0 write, 1 read).
  - Bits14:8 = address.
  - Bits7:0 = write data, or don't-care (o_sdat=0) on reads.
- Bit timing:
  - Each bit is SCK low for H cycles, then high for H cycles.
  - o_sdat changes only at the start of the low half.
  - HDP samples on the SCK rising edge.
  - Read data: i_sout is sampled on the cycle SCK rises during bits 7:0 and shifted into an internal register.
- States:
  - IDLE
    - i_txBegin=1: latch address/data, go to LEAD, kind=write.
    - Else i_rxBegin=1: latch address, go to LEAD, kind=read.
    - Write has priority on simultaneous strobes; the read strobe is dropped, not queued.
  - LEAD: o_sen=0, SCK low, o_sdat=bit15; H cycles.
  - SHIFT: 16 bit periods. Counter 0..15, sub-counter 0..CLOCKS_PER_BIT-1.
  - TRAIL: SCK low, o_sen=0, H cycles.
  - GAP: o_sen=1, o_sdat=0, CLOCKS_PER_BIT cycles.
  - DONE: single cycle.
    - Pulse o_txDone or o_rxDone.
    - Read: load o_rxData in the same cycle.
    - Return to IDLE.
- Busy timing:
  - Busy rises the cycle after the strobe is sampled.
  - Busy falls in the DONE cycle, i.e. busy and done are never high together.
  - Only the busy flag matching the frame kind asserts.
- Latency: the done pulse occurs exactly 18·CLOCKS_PER_BIT+1 cycles after the strobe-sampling edge (901 at default).
- Strobes while not IDLE, including in DONE, are ignored.
- Callers hold a strobe high for ≥1 cycle. A strobe held high through DONE starts a new frame on the following IDLE cycle.
- Address/data inputs may change after the sampling cycle.
- Counters are sized by $clog2 of CLOCKS_PER_BIT and must not wrap within a frame.

Optional Feature:
- Macro: HDP_SPI_WRITE_VERIFY_EN.
- Enabled:
  - After a write's GAP, the block automatically issues a read frame to the same address; o_txBusy stays high throughout.
  - On completion, o_txDone pulses.
  - o_txError is set if the readback ≠ written data, cleared otherwise. It is held until the next write completes.
  - o_rxData, o_rxBusy and o_rxDone are not affected by verify reads.
  - Write latency becomes 36·CLOCKS_PER_BIT+2.
- Disabled: o_txError is tied 0 and write latency is as above.

Test Plan:
- Write: i_txBegin pulse, address 0x01, data 0x02, CLOCKS_PER_BIT=50.
  - Expected: o_sdat bit sequence 0,0000001,00000010 on 16 SCK rising edges.
  - o_sen low for 17·50 cycles.
  - o_txDone pulse at cycle 901; o_rxDone never asserts.
- Read: address 0x78, model drives i_sout = 0x20 MSB first.
  - Expected: first transmitted bit =1, address bits 1111000.
  - o_rxData=0x20 in the o_rxDone cycle, held afterwards.
- Simultaneous i_txBegin and i_rxBegin: expected write frame only, o_rxBusy stays 0, single o_txDone.
- i_rxBegin pulsed mid-write (cycle 300): expected to be ignored, with exactly one done pulse in total.
- i_reset asserted at cycle 400 of a write: expected o_sen=1, o_sck=0, busy=0 immediately, no o_txDone, and the next request runs normally.
- HDP_SPI_WRITE_VERIFY_EN build, write 0x30 to address 0x08, model returns 0x31.
  - Expected: o_txError=1 with o_txDone at cycle 1802, o_rxDone silent.
  - Repeat with matching readback: expected o_txError=0.
